adder_share_arb: RTL



---
 rtl/mac_pkg.sv | 13 +
 rtl/adder_share_arb_if.sv | 35 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_share_arb.sv | 95 +++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC types: adder-share FSM states and default widths
package mac_pkg;

  localparam int W_DEFAULT    = 12;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_share_arb_if.sv
// rtl/adder_share_arb_if.sv - requester, shared-adder and response signals of adder_share_arb
interface adder_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 12,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;

  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_sum;
  logic              add_cout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  // master: requesters, response consumer and the external adder
  modport master (
    output req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr_i, with wrap
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin sequencer time-sharing one external adder among NREQ requesters
// Optional build macro: ADDER_SHARE_OPISO_EN (operand isolation on add_a/add_b outside EXEC)
module adder_share_arb
  import mac_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int W    = W_DEFAULT,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_share_arb_if.slave bus
);

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    gnt_a;
  logic [W-1:0]    gnt_b;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx)
  );

  assign gnt_any = |gnt_oh;
  assign gnt_a   = bus.req_a[gnt_idx*W +: W];
  assign gnt_b   = bus.req_b[gnt_idx*W +: W];

  // Pointer moves past the requester just served, so it becomes lowest priority next round
  assign rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  // Gated by rst_n so the accept strobe is silent while reset is held
  assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            op_a_q  <= gnt_a;
            op_b_q  <= gnt_b;
            id_q    <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          sum_q   <= bus.add_sum;
          cout_q  <= bus.add_cout;
          state_q <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADDER_SHARE_OPISO_EN
  assign bus.add_a = (state_q == EXEC) ? op_a_q : '0;
  assign bus.add_b = (state_q == EXEC) ? op_b_q : '0;
`else
  assign bus.add_a = op_a_q;
  assign bus.add_b = op_b_q;
`endif

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

endmodule
